decoder38_strobe: RTL and testbench

Sequential 3-to-8 decoder, the inverse of the team's 8-to-3 encoder. Accepts 3-bit codes over a valid/ready handshake and drives the matching one-hot line for a fixed dwell time, followed by an optional all-zero gap. A one-entry pending buffer lets the upstream hand over the next code while the current one is still displayed. Its output feeds one-hot consumers such as LED/column selects, and it loops back cleanly into `encoder83` for self-check benches.

---
 rtl/decoder38_pkg.sv | 19 +
 rtl/decoder38_comb.sv | 16 +
 rtl/decoder38_strobe.sv | 125 ++++++++++++
 tb/tb_decoder38_strobe.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/decoder38_pkg.sv
// Shared definitions for the sequential 3-to-8 strobe decoder.
//   CODE_W / OUT_W      : code width and one-hot output width
//   ST_IDLE/DWELL/GAP   : state encodings, wrapped by the stateT enum
package decoder38_pkg;

    localparam int unsigned CODE_W = 3;
    localparam int unsigned OUT_W  = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DWELL = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    typedef enum logic [1:0] {
        sIdle  = ST_IDLE,
        sDwell = ST_DWELL,
        sGap   = ST_GAP
    } stateT;

endpackage

// File: rtl/decoder38_comb.sv
// Purely combinational 3-to-8 one-hot decode.
//   iCode   : binary code
//   oOneHot : one-hot vector with bit iCode set
module decoder38_comb
    import decoder38_pkg::*;
(
    input  logic [CODE_W-1:0] iCode,
    output logic [OUT_W-1:0]  oOneHot
);

    always_comb begin
        oOneHot        = '0;
        oOneHot[iCode] = 1'b1;
    end

endmodule

// File: rtl/decoder38_strobe.sv
// Sequential 3-to-8 decoder: each accepted code is shown one-hot on oData for
// DWELL cycles, followed by GAP all-zero cycles. A one-entry pending buffer
// lets the next code be handed over while the current one is displayed.
//   iClk, iRst_n : clock (rising edge), asynchronous active-low reset
//   iData/iValid : code input, accepted when iValid && oReady
//   oReady       : pending buffer empty (registered)
//   oData        : registered one-hot output
//   oBusy        : state is not idle
//   oDone        : pulse on the last cycle of each symbol
module decoder38_strobe
    import decoder38_pkg::*;
#(
    parameter int unsigned DWELL = 4, // must be >= 1
    parameter int unsigned GAP   = 1
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic [CODE_W-1:0] iData,
    input  logic              iValid,
    output logic              oReady,
    output logic [OUT_W-1:0]  oData,
    output logic              oBusy,
    output logic              oDone
);

    localparam int unsigned CNT_MAX = (DWELL > GAP) ? DWELL : GAP;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP > 0) ? GAP - 1 : 0);

    // A symbol that is a single dwell cycle with no gap ends on its first cycle.
    localparam logic DONE_ON_ENTRY = (GAP == 0) && (DWELL == 1);
    // A one-cycle gap is the symbol's last cycle as soon as it is entered.
    localparam logic DONE_ON_GAP   = (GAP == 1);
    localparam logic NO_GAP        = (GAP == 0);

    stateT             state;
    logic [CNT_W-1:0]  cnt;
    logic              bufFull;
    logic [CODE_W-1:0] bufCode;

    logic              accept;
    logic              cntZero;
    logic              symEnd;
    logic [CODE_W-1:0] loadCode;
    logic [OUT_W-1:0]  loadOneHot;

    assign oReady   = ~bufFull;
    assign accept   = iValid & oReady;
    assign cntZero  = (cnt == '0);
    // Current cycle is the last one of the displayed symbol.
    assign symEnd   = cntZero & ((state == sGap) | ((state == sDwell) & NO_GAP));
    // A buffered code always takes precedence; when empty, the live input is
    // loaded (from idle, or as a same-cycle bypass at end of symbol).
    assign loadCode = bufFull ? bufCode : iData;

    decoder38_comb uDecode (
        .iCode   (loadCode),
        .oOneHot (loadOneHot)
    );

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state   <= sIdle;
            cnt     <= '0;
            bufFull <= 1'b0;
            bufCode <= '0;
            oData   <= '0;
            oBusy   <= 1'b0;
            oDone   <= 1'b0;
        end else begin
            oDone <= 1'b0;

            // Park a code that arrives mid-symbol; at symbol end it bypasses.
            if (accept && (state != sIdle) && !symEnd) begin
                bufFull <= 1'b1;
                bufCode <= iData;
            end

            unique case (state)
                sIdle: begin
                    if (accept) begin
                        state <= sDwell;
                        cnt   <= DWELL_LOAD;
                        oData <= loadOneHot;
                        oBusy <= 1'b1;
                        oDone <= DONE_ON_ENTRY;
                    end
                end
                sDwell, sGap: begin
                    if (symEnd) begin
                        if (bufFull || accept) begin
                            state   <= sDwell;
                            cnt     <= DWELL_LOAD;
                            oData   <= loadOneHot;
                            bufFull <= 1'b0;
                            oDone   <= DONE_ON_ENTRY;
                        end else begin
                            state <= sIdle;
                            oData <= '0;
                            oBusy <= 1'b0;
                        end
                    end else if (!cntZero) begin
                        cnt   <= cnt - CNT_W'(1);
                        // Next cycle is the last one of the symbol.
                        oDone <= (cnt == CNT_W'(1)) && ((state == sGap) || NO_GAP);
                    end else begin
                        // Dwell finished and a gap follows.
                        state <= sGap;
                        cnt   <= GAP_LOAD;
                        oData <= '0;
                        oDone <= DONE_ON_GAP;
                    end
                end
                default: begin
                    state <= sIdle;
                    oData <= '0;
                    oBusy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decoder38_strobe.sv
// Directed bench for decoder38_strobe: one instance with DWELL=4/GAP=1 and one
// with DWELL=4/GAP=0. Outputs are sampled 1 time unit after each rising edge.
module tb_decoder38_strobe;

    logic       clk = 1'b0;
    logic       rstN;
    logic [2:0] aData, bData;
    logic       aValid, bValid;
    logic       aReady, bReady;
    logic [7:0] aOut, bOut;
    logic       aBusy, bBusy, aDone, bDone;

    int errCnt = 0;
    int chkCnt = 0;

    always #5 clk = ~clk;

    decoder38_strobe #(.DWELL(4), .GAP(1)) uDutA (
        .iClk   (clk),
        .iRst_n (rstN),
        .iData  (aData),
        .iValid (aValid),
        .oReady (aReady),
        .oData  (aOut),
        .oBusy  (aBusy),
        .oDone  (aDone)
    );

    decoder38_strobe #(.DWELL(4), .GAP(0)) uDutB (
        .iClk   (clk),
        .iRst_n (rstN),
        .iData  (bData),
        .iValid (bValid),
        .oReady (bReady),
        .oData  (bOut),
        .oBusy  (bBusy),
        .oDone  (bDone)
    );

    task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chkCnt++;
        if (act !== exp) begin
            errCnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference 8-to-3 encoder for loopback checks.
    function automatic int enc83(input logic [7:0] v);
        int r = -1;
        for (int i = 0; i < 8; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkA(input string tag, input logic [7:0] d, input logic r, input logic b,
                          input logic dn);
        checkVal({tag, ".A.oData"}, aOut, d);
        checkVal({tag, ".A.oReady"}, aReady, r);
        checkVal({tag, ".A.oBusy"}, aBusy, b);
        checkVal({tag, ".A.oDone"}, aDone, dn);
    endtask

    task automatic checkB(input string tag, input logic [7:0] d, input logic r, input logic b,
                          input logic dn);
        checkVal({tag, ".B.oData"}, bOut, d);
        checkVal({tag, ".B.oReady"}, bReady, r);
        checkVal({tag, ".B.oBusy"}, bBusy, b);
        checkVal({tag, ".B.oDone"}, bDone, dn);
    endtask

    initial begin
        int  idx;
        int  sym;
        int  pos;
        bit  accPrev;
        bit  expR;
        logic [7:0] expD;

        // Reset with random inputs
        rstN   = 1'b0;
        aValid = 1'($urandom);
        aData  = 3'($urandom);
        bValid = 1'($urandom);
        bData  = 3'($urandom);
        for (int i = 0; i < 3; i++) begin
            tick();
            aValid = 1'($urandom);
            aData  = 3'($urandom);
            bValid = 1'($urandom);
            bData  = 3'($urandom);
        end
        checkA("reset", 8'h00, 1'b1, 1'b0, 1'b0);
        checkB("reset", 8'h00, 1'b1, 1'b0, 1'b0);
        aValid = 1'b0;
        bValid = 1'b0;
        @(negedge clk) rstN = 1'b1;
        tick();

        // Single code 5
        aValid = 1'b1;
        aData  = 3'd5;
        tick();
        aValid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) tick();
            if (c <= 4)      checkA($sformatf("single.c%0d", c), 8'h20, 1'b1, 1'b1, 1'b0);
            else if (c == 5) checkA("single.c5", 8'h00, 1'b1, 1'b1, 1'b1);
            else             checkA("single.c6", 8'h00, 1'b1, 1'b0, 1'b0);
        end

        // Stream 7..0 with iValid held; period 5, buffer refills each symbol
        idx     = 0;
        aValid  = 1'b1;
        aData   = 3'd7;
        accPrev = 1'b1;
        for (int c = 1; c <= 41; c++) begin
            tick();
            if (accPrev) idx++;
            sym  = (c - 1) / 5;
            pos  = (c - 1) % 5;
            expD = (sym < 8 && pos < 4) ? (8'h01 << (7 - sym)) : 8'h00;
            expR = (c > 35) || (pos == 0);
            checkA($sformatf("stream.c%0d", c), expD, expR, sym < 8, (sym < 8) && (pos == 4));
            if (sym < 8 && pos < 4)
                checkVal($sformatf("stream.loop.c%0d", c), enc83(aOut), 7 - sym);
            aValid  = (idx < 8);
            aData   = 3'(7 - idx);
            accPrev = aValid && expR;
        end
        aValid = 1'b0;

        // Accept on the last gap cycle bypasses straight into a new dwell
        aValid = 1'b1;
        aData  = 3'd4;
        tick();
        aValid = 1'b0;
        checkA("bypass.c1", 8'h10, 1'b1, 1'b1, 1'b0);
        repeat (4) tick();
        checkA("bypass.c5", 8'h00, 1'b1, 1'b1, 1'b1);
        aValid = 1'b1;
        aData  = 3'd1;
        tick();
        aValid = 1'b0;
        checkA("bypass.c6", 8'h02, 1'b1, 1'b1, 1'b0);
        repeat (3) tick();
        checkA("bypass.c9", 8'h02, 1'b1, 1'b1, 1'b0);
        tick();
        checkA("bypass.c10", 8'h00, 1'b1, 1'b1, 1'b1);
        tick();
        checkA("bypass.c11", 8'h00, 1'b1, 1'b0, 1'b0);

        // Reset mid-dwell with a pending code
        aValid = 1'b1;
        aData  = 3'd6;
        tick();
        aData  = 3'd3;
        tick();
        aValid = 1'b0;
        checkA("midrst.pre", 8'h40, 1'b0, 1'b1, 1'b0);
        #3 rstN = 1'b0;
        #1;
        checkA("midrst.async", 8'h00, 1'b1, 1'b0, 1'b0);
        @(negedge clk) rstN = 1'b1;
        tick();
        checkA("midrst.idle", 8'h00, 1'b1, 1'b0, 1'b0);
        aValid = 1'b1;
        aData  = 3'd2;
        tick();
        aValid = 1'b0;
        checkA("midrst.c1", 8'h04, 1'b1, 1'b1, 1'b0);
        repeat (4) tick();
        checkA("midrst.c5", 8'h00, 1'b1, 1'b1, 1'b1);
        tick();
        checkA("midrst.c6", 8'h00, 1'b1, 1'b0, 1'b0);

        // GAP=0: codes 0 then 3 back-to-back
        bValid = 1'b1;
        bData  = 3'd0;
        tick();
        bData  = 3'd3;
        checkB("nogap.c1", 8'h01, 1'b1, 1'b1, 1'b0);
        tick();
        bValid = 1'b0;
        checkB("nogap.c2", 8'h01, 1'b0, 1'b1, 1'b0);
        tick();
        checkB("nogap.c3", 8'h01, 1'b0, 1'b1, 1'b0);
        tick();
        checkB("nogap.c4", 8'h01, 1'b0, 1'b1, 1'b1);
        tick();
        checkB("nogap.c5", 8'h08, 1'b1, 1'b1, 1'b0);
        checkVal("nogap.loop", enc83(bOut), 3);
        repeat (2) tick();
        checkB("nogap.c7", 8'h08, 1'b1, 1'b1, 1'b0);
        tick();
        checkB("nogap.c8", 8'h08, 1'b1, 1'b1, 1'b1);
        tick();
        checkB("nogap.c9", 8'h00, 1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule
